// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared opcodes, select/state encodings and slot types for hazard_ctrl
package hazard_ctrl_pkg;

    // RV32I major opcodes
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // Operand forwarding select encoding
    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_P1 = 2'd1;
    localparam logic [1:0] SEL_P2 = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_t;

    // Destination tracking for an instruction ahead of decode
    typedef struct packed {
        logic       valid;
        logic       wr;
        logic       load;
        logic [4:0] rd;
    } slot_t;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic is_load;
        logic op_a_pc;
        logic op_b_imm;
    } instr_class_t;

    // x0 never produces a forwardable result
    function automatic logic slot_match(input slot_t s, input logic [4:0] r);
        return s.valid && s.wr && (s.rd != 5'd0) && (s.rd == r);
    endfunction

endpackage

// File: rtl/hazard_ctrl_instr_class.sv
// rtl/hazard_ctrl_instr_class.sv - opcode classifier shared by hazard control and operand mux
// Ports:
//   opcode : instruction bits [6:0]
//   cls    : {uses_rs1, uses_rs2, writes_rd, is_load, op_a_pc, op_b_imm}
module hazard_ctrl_instr_class
    import hazard_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t cls
);

    always_comb begin
        cls = '0;
        unique case (opcode)
            OP_R: begin
                cls.uses_rs1  = 1'b1;
                cls.uses_rs2  = 1'b1;
                cls.writes_rd = 1'b1;
            end
            OP_I: begin
                cls.uses_rs1  = 1'b1;
                cls.writes_rd = 1'b1;
                cls.op_b_imm  = 1'b1;
            end
            OP_L: begin
                cls.uses_rs1  = 1'b1;
                cls.writes_rd = 1'b1;
                cls.is_load   = 1'b1;
                cls.op_b_imm  = 1'b1;
            end
            OP_S: begin
                cls.uses_rs1  = 1'b1;
                cls.uses_rs2  = 1'b1;
                cls.op_b_imm  = 1'b1;
            end
            OP_B: begin
                cls.uses_rs1  = 1'b1;
                cls.uses_rs2  = 1'b1;
                cls.op_a_pc   = 1'b1;
                cls.op_b_imm  = 1'b1;
            end
            OP_LUI: begin
                cls.writes_rd = 1'b1;
                cls.op_b_imm  = 1'b1;
            end
            OP_AUIPC: begin
                cls.writes_rd = 1'b1;
                cls.op_a_pc   = 1'b1;
                cls.op_b_imm  = 1'b1;
            end
            OP_JAL: begin
                cls.writes_rd = 1'b1;
                cls.op_a_pc   = 1'b1;
                cls.op_b_imm  = 1'b1;
            end
            OP_JALR: begin
                cls.uses_rs1  = 1'b1;
                cls.writes_rd = 1'b1;
                cls.op_a_pc   = 1'b1;
                cls.op_b_imm  = 1'b1;
            end
            default: cls = '0;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding selects, load-use stall, branch flush and dmem freeze
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   id_instr, id_valid        : decode-stage instruction and its valid flag
//   ex_taken                  : branch/jump resolved taken in EX
//   dmem_req, dmem_ready      : MEM-stage access pending / completing
//   fwd_a_sel, fwd_b_sel      : rs1/rs2 source (SEL_RF / SEL_P1 / SEL_P2)
//   op_a_pc, op_b_imm         : operand A = pc, operand B = imm
//   hold_pc, hold_if_id       : load-use stall holds
//   flush_if_id, bubble_id_ex : bubble insertion
//   freeze                    : whole pipeline holds for data memory
//   state                     : RUN / LU_STALL / MEM_WAIT
//   stall_cnt, flush_cnt      : saturating performance counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             ex_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             op_a_pc,
    output logic             op_b_imm,
    output logic             hold_pc,
    output logic             hold_if_id,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    instr_class_t cls;
    slot_t        s1;
    slot_t        s2;
    hz_state_t    state_q;

    logic m1_rs1, m1_rs2, m2_rs1, m2_rs2;
    logic use_a, use_b;
    logic load_use;
    logic freeze_c;

    // funct3/funct7 are irrelevant to hazard detection
    logic unused_instr_bits;
    assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12]};

    assign rs1 = id_instr[19:15];
    assign rs2 = id_instr[24:20];
    assign rd  = id_instr[11:7];

    hazard_ctrl_instr_class u_instr_class (
        .opcode (id_instr[6:0]),
        .cls    (cls)
    );

    assign m1_rs1 = slot_match(s1, rs1);
    assign m1_rs2 = slot_match(s1, rs2);
    assign m2_rs1 = slot_match(s2, rs1);
    assign m2_rs2 = slot_match(s2, rs2);

    assign use_a = id_valid && cls.uses_rs1;
    assign use_b = id_valid && cls.uses_rs2;

    // Youngest producer wins: past1 before past2
    assign fwd_a_sel = !use_a ? SEL_RF : m1_rs1 ? SEL_P1 : m2_rs1 ? SEL_P2 : SEL_RF;
    assign fwd_b_sel = !use_b ? SEL_RF : m1_rs2 ? SEL_P1 : m2_rs2 ? SEL_P2 : SEL_RF;

    assign op_a_pc  = id_valid && cls.op_a_pc;
    assign op_b_imm = id_valid && cls.op_b_imm;

    // A load in S1 has no data until MEM completes, so a consumer must wait one cycle
    assign load_use = s1.load && ((use_a && m1_rs1) || (use_b && m1_rs2));

    assign freeze_c = dmem_req && !dmem_ready;

    // Freeze masks everything; a taken branch makes the decode instruction wrong-path,
    // so it also cancels any load-use stall on it
    assign freeze       = freeze_c;
    assign hold_pc      = !freeze_c && !ex_taken && load_use;
    assign hold_if_id   = hold_pc;
    assign flush_if_id  = !freeze_c && ex_taken;
    assign bubble_id_ex = !freeze_c && (ex_taken || load_use);

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            state_q   <= ST_RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!freeze_c) begin
                s2 <= s1;
                if (ex_taken || load_use || !id_valid) begin
                    s1 <= '0;
                end else begin
                    s1 <= '{valid: 1'b1, wr: cls.writes_rd, load: cls.is_load, rd: rd};
                end
            end

            if (freeze_c) begin
                state_q <= ST_MEM_WAIT;
            end else if (hold_pc) begin
                state_q <= ST_LU_STALL;
            end else begin
                state_q <= ST_RUN;
            end

            if (hold_pc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_if_id && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It tracks the destination registers of the two instructions ahead of decode and generates the operand-forwarding selects that drive the decode-side operand mux (regfile / past1 / past2, plus the pc/imm operand selects). It also generates the load-use stall, the branch-redirect flush and the data-memory freeze for all pipeline registers, and keeps saturating stall and flush counters.

## Interface
- `CNT_W`, default 16: width of the performance counters.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `id_instr` in 32: instruction currently in decode.
- `id_valid` in 1: `id_instr` is a real instruction, not a bubble.
- `ex_taken` in 1: branch or jump resolved taken in EX this cycle.
- `dmem_req` in 1: MEM stage has an active load or store.
- `dmem_ready` in 1: data memory completes the MEM access this cycle.
- `fwd_a_sel` out 2: rs1 source. 0 = regfile, 1 = past1 (MEM result), 2 = past2 (WB result).
- `fwd_b_sel` out 2: rs2 source, same encoding; also selects store data.
- `op_a_pc` out 1: operand A = pc. Set for B, AUIPC, JAL, JALR.
- `op_b_imm` out 1: operand B = imm. Set for S, I, B, JAL, JALR, LUI, AUIPC, L.
- `hold_pc` out 1: PC keeps its value.
- `hold_if_id` out 1: IF/ID register keeps its value.
- `flush_if_id` out 1: IF/ID register loads a bubble.
- `bubble_id_ex` out 1: ID/EX register loads a bubble.
- `freeze` out 1: every pipeline register, including EX/MEM and MEM/WB, holds.
- `state` out 2: 0 RUN, 1 LU_STALL, 2 MEM_WAIT.
- `stall_cnt` out CNT_W: saturating count of cycles with `hold_pc` set.
- `flush_cnt` out CNT_W: saturating count of cycles with `flush_if_id` set.

## Operation
- Decode of `id_instr`:
  - opcode = bits[6:0], rs1 = [19:15], rs2 = [24:20], rd = [11:7].
  - uses_rs1: R, I, L, S, B, JALR.
  - uses_rs2: R, S, B.
  - writes_rd: R, I, L, LUI, AUIPC, JAL, JALR.
  - is_load: L.
  - All opcode constants come from the shared defines.
- Tracking slots S1 (one instruction ahead, result on past1) and S2 (two ahead, result on past2). Each slot holds {valid, wr, load, rd[4:0]}.
- A slot matches source register r when: valid && wr && rd != 0 && rd == r. x0 never forwards.
- Forwarding, for each source:
  - sel = 1 if S1 matches.
  - else sel = 2 if S2 matches.
  - else sel = 0.
  - sel = 0 whenever `id_valid` = 0 or the operand is unused.
- Load-use condition: `id_valid` && S1.load && S1 matches (rs1 with uses_rs1, or rs2 with uses_rs2).
- Priority, highest first:
  1. freeze = `dmem_req` && !`dmem_ready`. All other control outputs are 0. Slots hold. `ex_taken` is ignored; the datapath keeps it asserted until the freeze ends.
  2. `ex_taken`: `flush_if_id` = 1 and `bubble_id_ex` = 1. Any load-use stall is cancelled because the decode instruction is wrong-path.
  3. Load-use: `hold_pc` = 1, `hold_if_id` = 1, `bubble_id_ex` = 1.
- Slot advance when not frozen:
  - S2 <= S1.
  - S1 <= invalid if (`ex_taken` || load-use || !`id_valid`); otherwise S1 <= decoded {1, writes_rd, is_load, rd}.
- FSM:
  - RUN -> LU_STALL on load-use.
  - RUN -> MEM_WAIT on freeze.
  - LU_STALL -> RUN the next cycle. The load has moved to S2 and the consumer takes past2.
  - MEM_WAIT -> RUN on the cycle after `dmem_ready`.
  - `state` is a registered copy of the condition active in the previous cycle. Freeze takes precedence over load-use when choosing the next state.
- Counters increment by 1 per qualifying cycle and stop at all-ones.

## Timing
- All selects and control outputs are combinational from inputs and slots, valid in the same cycle. Slots, FSM and counters update on posedge `clk`.
- Reset:
  - Slots invalid.
  - `state` = RUN.
  - Both counters = 0.
  - Outputs with `id_valid` = 0 and `dmem_req` = 0: every select = 0 and every control output = 0.
- Reset asserted mid-stall or mid-freeze clears everything on that edge. No leftover bubble.
- Load-use costs exactly 1 cycle. A taken branch costs 2 bubbles (IF/ID and ID/EX).
- With back-to-back writers to the same rd, past1 beats past2.

## Structure
- Opcode constants, the fwd-select encoding (SEL_RF / SEL_P1 / SEL_P2) and the state encoding belong in the shared defines/package.
- Natural sub-module: `instr_class`, a combinational decoder from opcode to {uses_rs1, uses_rs2, writes_rd, is_load, op_a_pc, op_b_imm}. It is reused by the operand mux.

## Test plan
- `addi x5,x0,1` then `add x6,x5,x5`: on the add, `fwd_a_sel` = `fwd_b_sel` = 1. One cycle later, a consumer of x5 gets sel = 2.
- `lw x7,0(x1)` then `add x8,x7,x2`: `hold_pc` = `hold_if_id` = `bubble_id_ex` = 1 for one cycle with `state` → LU_STALL. Next cycle `fwd_a_sel` = 2 and `stall_cnt` = 1.
- `addi x0,x0,5` then `add x9,x0,x0`: both selects = 0.
- Load-use condition and `ex_taken` in the same cycle: `flush_if_id` = `bubble_id_ex` = 1, `hold_pc` = 0, `flush_cnt` +1.
- `dmem_req` = 1 with `dmem_ready` low for 3 cycles: `freeze` = 1 for 3 cycles, slots and selects unchanged, `state` = MEM_WAIT, `stall_cnt` unchanged.
- Reset asserted during LU_STALL: next cycle `state` = RUN, counters 0, no bubble.
